load_store_unit: RTL and testbench

//   Downstream neighbour of the ALU. Uses the ALU Result as the effective address of a load/store.

---
 rtl/load_store_unit.sv | 204 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit sitting after the ALU. It turns the ALU result into a
// word-aligned request on a req/ack data bus and builds byte enables and
// lane-replicated store data. Load data is returned sign- or zero-extended.
// The core is stalled while a transfer is outstanding. Misaligned accesses
// are flagged instead of issued, and a stuck bus is aborted after a timeout.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic [2:0]  funct3,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        MisalignLd,
  output logic        MisalignSt,
  output logic        BusErr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Counter value on the last REQ cycle that still waits for an ack.
  // With TIMEOUT_CYCLES == 0 this wraps, but the comparison is then disabled.
  localparam logic [31:0] TO_LAST = TIMEOUT_CYCLES - 1;

  logic [1:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] rdata_q, rdata_d;
  logic        buserr_q, buserr_d;

  logic        access;
  logic        is_word;
  logic        is_half;
  logic        misalign;
  logic        in_idle;
  logic        start;
  logic        timeout_hit;

  // Byte enables for a store. The size comes from funct3[1:0] only,
  // so the unsigned bit has no effect on stores.
  function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] lane);
    case (sz)
      2'b00:   return 4'b0001 << lane;
      2'b01:   return 4'b0011 << {lane[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  // Store data copied onto every lane it could land on.
  function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Select the addressed byte/half of the returned word and extend it.
  // funct3 codes 011/110/111 fall into the word case.
  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [2:0] f3,
                                              input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3[1:0])
      2'b00:   return f3[2] ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   return f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  // Decode the incoming request and derive the combinational flags.
  always_comb begin
    access      = MemRead | MemWrite;
    is_word     = funct3[1];
    is_half     = (funct3[1:0] == 2'b01);
    misalign    = (is_word && (ALUResult[1:0] != 2'b00)) || (is_half && ALUResult[0]);
    in_idle     = (state_q == IDLE);
    start       = in_idle && access && !misalign;
    MisalignLd  = in_idle && access && misalign && !MemWrite;
    MisalignSt  = in_idle && access && misalign && MemWrite;
    Stall       = start || (state_q == REQ);
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);
  end

  // Next-state logic: issue in IDLE, wait for ack or timeout in REQ, retire in DONE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    f3_d     = f3_q;
    lane_d   = lane_q;
    rdata_d  = rdata_q;
    buserr_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = REQ;
          cnt_d   = 32'd0;
          req_d   = 1'b1;
          we_d    = MemWrite;
          addr_d  = {ALUResult[31:2], 2'b00};
          be_d    = MemWrite ? store_be(funct3[1:0], ALUResult[1:0]) : 4'b1111;
          wdata_d = store_data(funct3[1:0], WriteData);
          f3_d    = funct3;
          lane_d  = ALUResult[1:0];
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          if (!we_q) begin
            rdata_d = load_extend(mem_rdata, f3_q, lane_q);
          end
        end else if (timeout_hit) begin
          state_d  = DONE;
          req_d    = 1'b0;
          buserr_d = 1'b1;
          if (!we_q) begin
            rdata_d = 32'd0;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      DONE: begin
        // The instruction retires here; any request present is not sampled.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and bus registers; reset drops the request immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= 32'd0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      be_q     <= 4'd0;
      wdata_q  <= 32'd0;
      f3_q     <= 3'd0;
      lane_q   <= 2'd0;
      rdata_q  <= 32'd0;
      buserr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      f3_q     <= f3_d;
      lane_q   <= lane_d;
      rdata_q  <= rdata_d;
      buserr_q <= buserr_d;
    end
  end

  assign ReadData  = rdata_q;
  assign BusErr    = buserr_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a byte-addressed reference memory predicts
// every bus transaction and load result; a monitor checks them as they appear.
module tb_load_store_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUResult, WriteData;
  logic [2:0]  funct3;
  logic        MemRead, MemWrite;
  logic [31:0] ReadData;
  logic        Stall, MisalignLd, MisalignSt, BusErr;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ALUResult(ALUResult), .WriteData(WriteData),
    .funct3(funct3), .MemRead(MemRead), .MemWrite(MemWrite), .ReadData(ReadData),
    .Stall(Stall), .MisalignLd(MisalignLd), .MisalignSt(MisalignSt), .BusErr(BusErr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  // Reference view of memory (bytes) and the bus-side memory (words).
  logic [7:0]  refmem [0:1023];
  logic [31:0] busmem [0:255];
  logic [31:0] last_rd;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        berr;
    int          nreq;
  } exp_t;
  exp_t sbq[$];

  int   ack_delay = 1;
  logic late_ack  = 1'b0;
  int   rc = 0;

  task automatic set_word(input logic [31:0] a, input logic [31:0] w);
    busmem[a[9:2]] = w;
    for (int b = 0; b < 4; b++) refmem[{a[9:2], 2'b00} + 10'(b)] = w[8*b +: 8];
  endtask

  // Memory slave: acks on the ack_delay-th REQ cycle, garbage data otherwise.
  always @(negedge clk) begin
    if (mem_req === 1'b1) begin
      rc++;
      mem_ack   = (rc == ack_delay);
      mem_rdata = mem_ack ? busmem[mem_addr[9:2]] : $urandom();
    end else begin
      rc        = 0;
      mem_ack   = late_ack;
      mem_rdata = $urandom();
    end
  end

  // Commit acknowledged writes into the bus memory using the DUT's enables.
  always @(posedge clk) begin
    if (rst && mem_req && mem_ack && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) busmem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
    end
  end

  // Monitor: checks request fields when mem_req rises and results in the retire cycle.
  logic prev_req = 1'b0;
  logic have_cur = 1'b0;
  exp_t cur;
  int   req_len = 0;
  always @(negedge clk) begin
    if (!rst) begin
      prev_req = 1'b0;
      have_cur = 1'b0;
    end else begin
      if (mem_req && !prev_req) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_req: got addr %h want no request", mem_addr);
          have_cur = 1'b0;
        end else begin
          cur      = sbq.pop_front();
          have_cur = 1'b1;
          req_len  = 0;
          chk("req_addr", mem_addr, cur.addr);
          chk("req_be", 32'(mem_be), 32'(cur.be));
          chk("req_we", 32'(mem_we), 32'(cur.we));
          if (cur.we) chk("req_wdata", mem_wdata, cur.wdata);
        end
      end
      if (mem_req && have_cur) begin
        req_len++;
        chk("addr_hold", mem_addr, cur.addr);
      end
      if (!mem_req && prev_req && have_cur) begin
        chk("req_len", req_len, cur.nreq);
        chk("done_buserr", 32'(BusErr), 32'(cur.berr));
        chk("done_readdata", ReadData, cur.rd);
        chk("done_stall", 32'(Stall), 32'd0);
        have_cur = 1'b0;
      end
      prev_req = mem_req;
    end
  end

  // One instruction: predict from the reference memory, drive, and count stall cycles.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] f3, input int dly);
    int          sz;
    logic        mis;
    exp_t        e;
    logic [31:0] v;
    int          st;
    int          guard;
    sz  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    mis = (int'(a[1:0]) % sz) != 0;
    @(negedge clk);
    ALUResult = a; WriteData = d; funct3 = f3; MemRead = rd; MemWrite = wr;
    ack_delay = dly;
    if (mis) begin
      #1;
      chk("mis_ld", 32'(MisalignLd), 32'(!wr));
      chk("mis_st", 32'(MisalignSt), 32'(wr));
      chk("mis_stall", 32'(Stall), 32'd0);
      @(posedge clk); #1;
      MemRead = 1'b0; MemWrite = 1'b0;
      chk("mis_noreq", 32'(mem_req), 32'd0);
      chk("mis_readdata", ReadData, last_rd);
      return;
    end
    e.addr = {a[31:2], 2'b00};
    e.we   = wr;
    e.berr = (dly > TO);
    e.nreq = (dly > TO) ? TO : dly;
    e.be   = 4'b0000;
    if (wr) begin
      for (int i = 0; i < sz; i++) e.be[int'(a[1:0]) + i] = 1'b1;
      e.wdata = (sz == 1) ? {4{d[7:0]}} : (sz == 2) ? {2{d[15:0]}} : d;
      e.rd    = last_rd;
      if (!e.berr)
        for (int i = 0; i < sz; i++) refmem[a[9:0] + 10'(i)] = d[8*i +: 8];
    end else begin
      e.be    = 4'b1111;
      e.wdata = 32'd0;
      v = 32'd0;
      if (!e.berr) begin
        for (int i = 0; i < sz; i++) v[8*i +: 8] = refmem[a[9:0] + 10'(i)];
        if (!f3[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
        if (!f3[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
      end
      last_rd = v;
      e.rd    = v;
    end
    sbq.push_back(e);
    #1;
    st = 0;
    guard = 0;
    while (Stall === 1'b1 && guard < 20) begin
      st++;
      @(posedge clk); #1;
      MemRead = 1'b0; MemWrite = 1'b0;
      guard++;
    end
    MemRead = 1'b0; MemWrite = 1'b0;
    chk("stall_cycles", st, 1 + e.nreq);
    @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, d;
    logic [2:0]  f3;
    int          k;
    rst = 1'b0; ALUResult = '0; WriteData = '0; funct3 = '0;
    MemRead = 1'b0; MemWrite = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    last_rd = '0;
    for (int i = 0; i < 256; i++) set_word(32'(i * 4), $urandom());

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_readdata", ReadData, 32'd0);
    chk("rst_buserr", 32'(BusErr), 32'd0);
    chk("rst_stall", 32'(Stall), 32'd0);
    rst = 1'b1;

    // SW with ack on the third REQ cycle.
    issue(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 3);
    chk("t1_addr", mem_addr, 32'h100);
    chk("t1_be", 32'(mem_be), 32'hF);
    chk("t1_wdata", mem_wdata, 32'hDEADBEEF);
    issue(1'b1, 1'b0, 32'h100, 32'h0, 3'b010, 1);
    chk("t1_readback", ReadData, 32'hDEADBEEF);

    // LB / LBU of the top byte of 0x80FF0000.
    set_word(32'h200, 32'h80FF0000);
    issue(1'b1, 1'b0, 32'h203, 32'h0, 3'b000, 2);
    chk("t2_lb", ReadData, 32'hFFFFFF80);
    issue(1'b1, 1'b0, 32'h203, 32'h0, 3'b100, 1);
    chk("t2_lbu", ReadData, 32'h00000080);

    // SH to upper half, with MemRead also high (store wins).
    issue(1'b1, 1'b1, 32'h102, 32'h1234ABCD, 3'b001, 1);
    chk("t3_be", 32'(mem_be), 32'hC);
    chk("t3_wdata", mem_wdata, 32'hABCDABCD);
    chk("t3_addr", mem_addr, 32'h100);

    // Misaligned word load and half store.
    issue(1'b1, 1'b0, 32'h101, 32'h0, 3'b010, 1);
    issue(1'b0, 1'b1, 32'h105, 32'h55, 3'b101, 1);

    // Timeout on a load, then a late ack that must be ignored.
    issue(1'b1, 1'b0, 32'h300, 32'h0, 3'b010, 99);
    chk("t5_readdata", ReadData, 32'd0);
    #1;
    late_ack = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("t5_late_req", 32'(mem_req), 32'd0);
      chk("t5_late_rd", ReadData, 32'd0);
      chk("t5_late_buserr", 32'(BusErr), 32'd0);
    end
    late_ack = 1'b0;

    // Reset while a load is outstanding.
    @(negedge clk);
    ALUResult = 32'h40; funct3 = 3'b010; MemRead = 1'b1; ack_delay = 99;
    sbq.push_back('{addr: 32'h40, be: 4'hF, we: 1'b0, wdata: 32'd0, rd: 32'd0, berr: 1'b0, nreq: 0});
    @(posedge clk); #1;
    MemRead = 1'b0;
    @(posedge clk); #1;
    chk("t6_req_before", 32'(mem_req), 32'd1);
    rst = 1'b0;
    #1;
    chk("t6_req_dropped", 32'(mem_req), 32'd0);
    chk("t6_stall", 32'(Stall), 32'd0);
    chk("t6_readdata", ReadData, 32'd0);
    last_rd = 32'd0;
    @(posedge clk); #2;
    rst = 1'b1;
    late_ack = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("t6_late_req", 32'(mem_req), 32'd0);
    end
    late_ack = 1'b0;
    set_word(32'h0, 32'hBEEF0000);
    issue(1'b1, 1'b0, 32'h2, 32'h0, 3'b101, 1);
    chk("t6_lhu", ReadData, 32'h0000BEEF);

    // Randomized mix of loads and stores.
    for (int n = 0; n < 200; n++) begin
      k  = $urandom_range(0, 2);
      a  = $urandom();
      d  = $urandom();
      f3 = 3'($urandom_range(0, 7));
      issue(k != 1, k != 0, a, d, f3, $urandom_range(1, 6));
    end

    repeat (3) @(posedge clk);
    chk("sb_empty", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
